vend_fsm_change: RTL and testbench
==================================

Name: vend_fsm_change

Overview:
Parametrised successor of the single-coin vending FSM. Accepts nickels, dimes and quarters, and accumulates credit up to a configurable limit. Vends when credit reaches PRICE, then returns any excess as a serial stream of CHANGE_UNIT change pulses. Supports cancel/refund and explicit coin rejection. Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

Parameters:
PRICE, 15, item price in cents; multiple of CHANGE_UNIT, >0
MAX_CREDIT, 95, largest credit accepted; PRICE <= MAX_CREDIT < 2**CREDIT_W
CREDIT_W, 8, width of credit register and credit output
CHANGE_UNIT, 5, value of one change pulse in cents

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
coin_valid  input  1  one-cycle strobe, coin present this cycle
coin_sel  input  2  00=5c, 01=10c, 10=25c, 11=invalid
cancel  input  1  one-cycle strobe, refund request
dispense  output  1  one-cycle vend pulse
change_pulse  output  1  one pulse per CHANGE_UNIT returned
coin_reject  output  1  one-cycle pulse, coin returned unaccepted
credit  output  CREDIT_W  current credit in cents
busy  output  1  high in VEND or CHANGE

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. State=IDLE, credit=0, and all 1-bit outputs 0 on the cycle after rst is sampled high. rst overrides all other inputs, including mid-VEND and mid-CHANGE; in-progress change is abandoned.
- All outputs are registered (Moore).
- States: IDLE (credit==0), COLLECT (0<credit<PRICE), VEND, CHANGE.
- IDLE/COLLECT, coin_valid with valid coin_sel:
  - new = credit + value.
  - new > MAX_CREDIT: coin_reject=1 next cycle, credit unchanged.
  - Otherwise credit <= new.
  - new >= PRICE: next state VEND. Otherwise next state COLLECT.
- coin_sel==11 with coin_valid: coin_reject, no credit change, in any state.
- VEND (1 cycle): dispense=1 and credit <= credit-PRICE. Next state is CHANGE if the remainder >0, else IDLE.
- CHANGE:
  - Each cycle change_pulse=1 and credit <= credit-CHANGE_UNIT.
  - Leave to IDLE on the cycle credit reaches 0.
  - Exactly (remainder/CHANGE_UNIT) pulses, back-to-back.
- cancel in COLLECT: next state CHANGE, full credit refunded; no dispense.
- cancel in IDLE, VEND or CHANGE: ignored.
- Simultaneous coin_valid and cancel in COLLECT: cancel wins, coin rejected (coin_reject=1).
- coin_valid during VEND or CHANGE: coin_reject=1, credit unaffected.
- busy = (state==VEND || state==CHANGE).
- Arithmetic uses CREDIT_W+1 bits internally for the overflow compare; no wrap-around is possible.
- Latency: accept edge N → dispense high in cycle N+1 → first change_pulse in cycle N+2.

Optional Feature:
VEND_STATS_EN:
- Defined: adds outputs vend_count[15:0] and refund_count[15:0], both saturating at 16'hFFFF and cleared by rst.
  - vend_count increments on each dispense.
  - refund_count increments on each accepted cancel.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Defaults, rst then 3 nickels on consecutive cycles → credit 5,10,15; dispense pulse 1 cycle after 3rd accept; no change_pulse; back to IDLE, credit 0.
2. Single quarter (PRICE=15) → dispense; credit 10; 2 back-to-back change_pulse; credit 0, IDLE; busy high exactly 3 cycles.
3. Dime then cancel → 2 change_pulse, dispense never asserts, credit 0 after.
4. PRICE=90, MAX_CREDIT=95:
   - 3 quarters → credit 75.
   - 4th quarter → coin_reject, credit stays 75.
   - Dime → 85.
   - Nickel → dispense, no change.
5. Quarter, then coin_valid with a dime on the first CHANGE cycle → coin_reject; total change pulses still 2.
6. Dime, then coin_valid and cancel on the same cycle → coin_reject and 2 change_pulse. Quarter again, rst asserted in CHANGE after 1 pulse → next cycle all outputs 0, credit 0, no further pulses.

Source files
------------

// File: rtl/vend_fsm_change_if.sv
// ---------------------------------------------------------------------------
// vend_fsm_change_if
// Bundles the coin-acceptor request side and the dispenser / change-hopper
// response side of the vending controller.
//   coin_valid, coin_sel, cancel     : driven by the coin-acceptor front end
//   dispense, change_pulse,
//   coin_reject, credit, busy        : driven by the vending controller
//   vend_count, refund_count         : statistics, present only when
//                                      VEND_STATS_EN is defined
// Modports: master = front end / test driver, slave = vending controller.
// ---------------------------------------------------------------------------
interface vend_fsm_change_if #(
    parameter int CREDIT_W = 8
);
    logic                coin_valid;
    logic [1:0]          coin_sel;
    logic                cancel;
    logic                dispense;
    logic                change_pulse;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
`ifdef VEND_STATS_EN
    logic [15:0]         vend_count;
    logic [15:0]         refund_count;
`endif

    modport master (
        output coin_valid, coin_sel, cancel,
        input  dispense, change_pulse, coin_reject, credit, busy
`ifdef VEND_STATS_EN
        , input vend_count, refund_count
`endif
    );

    modport slave (
        input  coin_valid, coin_sel, cancel,
        output dispense, change_pulse, coin_reject, credit, busy
`ifdef VEND_STATS_EN
        , output vend_count, refund_count
`endif
    );
endinterface

// File: rtl/vend_fsm_change.sv
// ---------------------------------------------------------------------------
// vend_fsm_change
// Vending controller accepting nickels, dimes and quarters. Credit builds up
// to MAX_CREDIT; once it reaches PRICE the item is dispensed and any excess
// is returned as back-to-back CHANGE_UNIT change pulses. A cancel while
// collecting refunds the whole credit through the same change path.
//
// Ports:
//   clk   : clock, all state on the rising edge
//   rst   : synchronous, active-high reset
//   bus   : vend_fsm_change_if.slave
//             coin_valid / coin_sel (00=5c 01=10c 10=25c 11=invalid) / cancel
//             dispense, change_pulse, coin_reject, credit, busy (registered)
//
// Optional feature (macro VEND_STATS_EN): saturating 16-bit vend_count and
// refund_count outputs on the interface. Without the macro they do not exist.
//
// Parameter constraints: PRICE > 0 and a multiple of CHANGE_UNIT,
// PRICE <= MAX_CREDIT < 2**CREDIT_W.
// ---------------------------------------------------------------------------
module vend_fsm_change #(
    parameter int PRICE       = 15,
    parameter int MAX_CREDIT  = 95,
    parameter int CREDIT_W    = 8,
    parameter int CHANGE_UNIT = 5
) (
    input  logic clk,
    input  logic rst,
    vend_fsm_change_if.slave bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_VEND    = 2'd2;
    localparam logic [1:0] S_CHANGE  = 2'd3;

    // One extra bit so credit + coin can exceed MAX_CREDIT without wrapping.
    localparam int SUM_W = CREDIT_W + 1;

    localparam logic [SUM_W-1:0]    MAX_W   = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0]    PRICE_W = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);

    logic [1:0]          state_q,  state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_d;
    logic [SUM_W-1:0]    coin_value;
    logic [SUM_W-1:0]    sum;
    logic                coin_ok;

    always_comb begin
        case (bus.coin_sel)
            2'b00:   coin_value = SUM_W'(5);
            2'b01:   coin_value = SUM_W'(10);
            2'b10:   coin_value = SUM_W'(25);
            default: coin_value = '0;
        endcase
    end

    assign sum     = {1'b0, credit_q} + coin_value;
    assign coin_ok = (bus.coin_sel != 2'b11) && (sum <= MAX_W);

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (state_q == S_COLLECT && bus.cancel) begin
                    // Cancel beats a simultaneous coin; credit drains via CHANGE.
                    state_d  = S_CHANGE;
                    reject_d = bus.coin_valid;
                end else if (bus.coin_valid) begin
                    if (coin_ok) begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= PRICE_W) ? S_VEND : S_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end

            S_VEND: begin
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q == PRICE_C) ? S_IDLE : S_CHANGE;
                reject_d = bus.coin_valid;
            end

            default: begin // S_CHANGE
                // Credit is always a multiple of CHANGE_UNIT here; the <=
                // guard only keeps a corrupted value from underflowing.
                if (credit_q <= UNIT_C) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    credit_d = credit_q - UNIT_C;
                end
                reject_d = bus.coin_valid;
            end
        endcase
    end

    // Outputs are registered decodes of the next state, so each one is high
    // during exactly the cycle the FSM spends in the matching state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            credit_q         <= '0;
            bus.dispense     <= 1'b0;
            bus.change_pulse <= 1'b0;
            bus.coin_reject  <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            state_q          <= state_d;
            credit_q         <= credit_d;
            bus.dispense     <= (state_d == S_VEND);
            bus.change_pulse <= (state_d == S_CHANGE);
            bus.coin_reject  <= reject_d;
            bus.busy         <= (state_d == S_VEND) || (state_d == S_CHANGE);
        end
    end

    assign bus.credit = credit_q;

`ifdef VEND_STATS_EN
    logic accepted_cancel;
    assign accepted_cancel = (state_q == S_COLLECT) && bus.cancel;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.vend_count   <= '0;
            bus.refund_count <= '0;
        end else begin
            if (state_q == S_VEND && bus.vend_count != 16'hFFFF)
                bus.vend_count <= bus.vend_count + 16'd1;
            if (accepted_cancel && bus.refund_count != 16'hFFFF)
                bus.refund_count <= bus.refund_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vend_fsm_change.sv
// ---------------------------------------------------------------------------
// tb_vend_fsm_change
// Scoreboarded bench for vend_fsm_change. dut_a uses default parameters,
// dut_b uses PRICE=90 / MAX_CREDIT=95. Stimulus pushes the expected output
// events (dispense / change_pulse / coin_reject plus the credit shown in that
// cycle) into a per-DUT queue; a monitor pops and compares on every falling
// edge where a DUT raises any event output. Quiet-state credit and busy are
// checked directly.
// ---------------------------------------------------------------------------
module tb_vend_fsm_change;

    typedef struct packed {
        logic       d;
        logic       c;
        logic       r;
        logic [7:0] cr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vend_fsm_change_if #(.CREDIT_W(8)) if_a ();
    vend_fsm_change_if #(.CREDIT_W(8)) if_b ();

    vend_fsm_change #(.PRICE(15), .MAX_CREDIT(95), .CREDIT_W(8), .CHANGE_UNIT(5))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    vend_fsm_change #(.PRICE(90), .MAX_CREDIT(95), .CREDIT_W(8), .CHANGE_UNIT(5))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    int  checks   = 0;
    int  failures = 0;
    int  busy_cnt = 0;
    ev_t q_a[$];
    ev_t q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int u, input logic d, input logic c, input logic r,
                        input logic [7:0] cr);
        ev_t e;
        e = '{d: d, c: c, r: r, cr: cr};
        if (u == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic mon_one(input string name, input ev_t obs, inout ev_t q[$]);
        ev_t e;
        if (obs.d || obs.c || obs.r) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL %s unexpected event: got d=%0b c=%0b r=%0b credit=%0d, expected none",
                         name, obs.d, obs.c, obs.r, obs.cr);
            end else begin
                e = q.pop_front();
                if (obs !== e) begin
                    failures++;
                    $display("FAIL %s event: got d=%0b c=%0b r=%0b credit=%0d, expected d=%0b c=%0b r=%0b credit=%0d",
                             name, obs.d, obs.c, obs.r, obs.cr, e.d, e.c, e.r, e.cr);
                end
            end
        end
    endtask

    task automatic monitor();
        ev_t oa, ob;
        forever begin
            @(negedge clk);
            oa = '{d: if_a.dispense, c: if_a.change_pulse, r: if_a.coin_reject, cr: if_a.credit};
            ob = '{d: if_b.dispense, c: if_b.change_pulse, r: if_b.coin_reject, cr: if_b.credit};
            mon_one("dut_a", oa, q_a);
            mon_one("dut_b", ob, q_b);
            if (if_a.busy) busy_cnt++;
        end
    endtask

    // Holds the given inputs for exactly one sampling edge, then clears them.
    task automatic step(input int u, input logic v, input logic [1:0] s, input logic c);
        if (u == 0) begin
            if_a.coin_valid = v; if_a.coin_sel = s; if_a.cancel = c;
        end else begin
            if_b.coin_valid = v; if_b.coin_sel = s; if_b.cancel = c;
        end
        @(posedge clk);
        #1;
        if_a.coin_valid = 1'b0; if_a.coin_sel = 2'b00; if_a.cancel = 1'b0;
        if_b.coin_valid = 1'b0; if_b.coin_sel = 2'b00; if_b.cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for the monitor to consume every expected event.
    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            idle(1);
        end
        check({name, " pending dut_a events"}, q_a.size(), 0);
        check({name, " pending dut_b events"}, q_b.size(), 0);
    endtask

    initial begin
        if_a.coin_valid = 1'b0; if_a.coin_sel = 2'b00; if_a.cancel = 1'b0;
        if_b.coin_valid = 1'b0; if_b.coin_sel = 2'b00; if_b.cancel = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        idle(3);
        rst = 1'b0;
        check("rst dispense",     if_a.dispense,     0);
        check("rst change_pulse", if_a.change_pulse, 0);
        check("rst coin_reject",  if_a.coin_reject,  0);
        check("rst credit",       if_a.credit,       0);
        check("rst busy",         if_a.busy,         0);
        check("rst credit b",     if_b.credit,       0);

        // 1: three nickels -> exact price, no change
        push(0, 1, 0, 0, 8'd15);
        step(0, 1, 2'b00, 0); check("t1 credit 5",  if_a.credit, 5);
        step(0, 1, 2'b00, 0); check("t1 credit 10", if_a.credit, 10);
        step(0, 1, 2'b00, 0); check("t1 credit 15", if_a.credit, 15);
        check("t1 busy in vend", if_a.busy, 1);
        idle(2);
        check("t1 credit end", if_a.credit, 0);
        check("t1 busy end",   if_a.busy,   0);
        drain("t1");

        // 2: quarter -> dispense + two change pulses, busy for 3 cycles
        push(0, 1, 0, 0, 8'd25);
        push(0, 0, 1, 0, 8'd10);
        push(0, 0, 1, 0, 8'd5);
        busy_cnt = 0;
        step(0, 1, 2'b10, 0);
        idle(5);
        check("t2 busy cycles", busy_cnt, 3);
        check("t2 credit end", if_a.credit, 0);
        drain("t2");

        // 3: dime then cancel -> full refund, no dispense
        push(0, 0, 1, 0, 8'd10);
        push(0, 0, 1, 0, 8'd5);
        step(0, 1, 2'b01, 0); check("t3 credit 10", if_a.credit, 10);
        step(0, 0, 2'b00, 1);
        idle(4);
        check("t3 credit end", if_a.credit, 0);
        drain("t3");

        // 4: PRICE=90 - overflow rejection then exact vend
        step(1, 1, 2'b10, 0); check("t4 credit 25", if_b.credit, 25);
        step(1, 1, 2'b10, 0); check("t4 credit 50", if_b.credit, 50);
        step(1, 1, 2'b10, 0); check("t4 credit 75", if_b.credit, 75);
        push(1, 0, 0, 1, 8'd75);
        step(1, 1, 2'b10, 0); check("t4 credit held", if_b.credit, 75);
        step(1, 1, 2'b01, 0); check("t4 credit 85", if_b.credit, 85);
        push(1, 1, 0, 0, 8'd90);
        step(1, 1, 2'b00, 0);
        idle(3);
        check("t4 credit end", if_b.credit, 0);
        drain("t4");

        // invalid coin while idle is rejected
        push(0, 0, 0, 1, 8'd0);
        step(0, 1, 2'b11, 0);
        idle(1);
        check("invalid coin credit", if_a.credit, 0);
        drain("inv");

        // 5: coin during first CHANGE cycle is rejected, change unaffected
        push(0, 1, 0, 0, 8'd25);
        push(0, 0, 1, 0, 8'd10);
        push(0, 0, 1, 1, 8'd5);
        step(0, 1, 2'b10, 0);
        idle(1);
        step(0, 1, 2'b01, 0);
        idle(3);
        check("t5 credit end", if_a.credit, 0);
        drain("t5");

        // 6a: coin + cancel together in COLLECT -> reject and refund
        push(0, 0, 1, 1, 8'd10);
        push(0, 0, 1, 0, 8'd5);
        step(0, 1, 2'b01, 0);
        step(0, 1, 2'b01, 1);
        idle(3);
        check("t6a credit end", if_a.credit, 0);
        drain("t6a");

        // 6b: reset mid-CHANGE after one pulse abandons the rest
        push(0, 1, 0, 0, 8'd25);
        push(0, 0, 1, 0, 8'd10);
        step(0, 1, 2'b10, 0);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6b dispense",     if_a.dispense,     0);
        check("t6b change_pulse", if_a.change_pulse, 0);
        check("t6b coin_reject",  if_a.coin_reject,  0);
        check("t6b credit",       if_a.credit,       0);
        check("t6b busy",         if_a.busy,         0);
        idle(4);
        check("t6b credit later", if_a.credit, 0);
        drain("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
